v_hier_sched: RTL

- Round-robin scheduler that shares one v_hier_sub datapath lane (avec in, qvec out) among NREQ requesters.
- Arbitrates among requesters and drives the winner's operand onto avec.
- Waits a fixed datapath latency, then samples qvec and returns the result tagged with the requester index.
- Sits directly above v_hier_sub; it is the only driver of avec.

---
 rtl/v_hier_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/v_hier_sched.sv
// Round-robin scheduler sharing one v_hier_sub datapath lane among NREQ requesters.
// Issues the winner's operand on avec, waits LATENCY cycles, returns qvec tagged with the winner id.
module v_hier_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 4,
   parameter int LATENCY = 2,
   parameter int IDW     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      avec,
   input  logic [WIDTH-1:0]      qvec,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  busy
);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_win;
   logic [IDW-1:0]   w_win;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_avec;
   logic [WIDTH-1:0] r_rsp_data;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] w_ops [NREQ];
   logic             w_last;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_ops[gi] = req_data[gi*WIDTH +: WIDTH];
      assign gnt[gi]   = (r_state == ISSUE) && (r_win == IDW'(gi));
   end

   // Scan from the farthest offset back toward ptr so the nearest requester wins.
   always_comb begin
      logic [IDW-1:0] v_idx;
      v_idx = '0;
      w_win = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         v_idx = IDW'((int'(r_ptr) + k) % NREQ);
         if (req[v_idx]) w_win = v_idx;
      end
   end

   assign w_last = (r_cnt == CW'(LATENCY - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (|req) w_state_next = ISSUE;
         ISSUE:   w_state_next = WAIT;
         WAIT:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_win      <= '0;
         r_cnt      <= '0;
         r_avec     <= '0;
         r_rsp_data <= '0;
         r_rsp_id   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_win  <= w_win;
                  r_avec <= w_ops[w_win];
               end
            end
            ISSUE: r_cnt <= '0;
            WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // Only the final wait cycle is sampled; avec drops as DONE begins.
               if (w_last) begin
                  r_rsp_data <= qvec;
                  r_rsp_id   <= r_win;
                  r_avec     <= '0;
               end
            end
            DONE:    r_ptr <= (r_win == IDW'(NREQ - 1)) ? '0 : r_win + 1'b1;
            default: ;
         endcase
      end
   end

   assign avec      = r_avec;
   assign rsp_valid = (r_state == DONE);
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign busy      = (r_state != IDLE);

endmodule
